// File: rtl/rv32i_accel_cmd_queue_pkg.sv
// Shared decode constants, queue entry layout and producer classification
// for the RV32I custom-instruction accelerator path.
package accel_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_ACCEL  = 7'b0000001;
  localparam logic [2:0] F3_AWR    = 3'b000;
  localparam logic [2:0] F3_START  = 3'b001;
  localparam logic [2:0] F3_STAT   = 3'b010;
  localparam logic [2:0] F3_BRD    = 3'b011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
  } accel_cmd_t;

  function automatic logic is_accel(input logic [31:0] instr);
    return (instr[6:0] == OPC_RTYPE) && (instr[31:25] == F7_ACCEL);
  endfunction

  // Only STAT and BRD write a destination; x0 is never tracked.
  function automatic logic is_producer(input logic [31:0] instr, input logic [4:0] rd);
    return is_accel(instr) &&
           ((instr[14:12] == F3_STAT) || (instr[14:12] == F3_BRD)) &&
           (rd != 5'd0);
  endfunction

endpackage

// File: rtl/rv32i_accel_cmd_queue_if.sv
// Core-side issue, accelerator-side dispatch and writeback signals of the
// command queue; slave is the queue's view, master the surrounding system's.
interface rv32i_accel_cmd_queue_if;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [31:0] cpu_instr;
  logic [31:0] cpu_rs1_val;
  logic [31:0] cpu_rs2_val;
  logic [4:0]  cpu_rd_addr;

  logic        acc_instr_valid;
  logic        acc_instr_ready;
  logic [31:0] acc_instr;
  logic [31:0] acc_rs1_val;
  logic [31:0] acc_rs2_val;
  logic [4:0]  acc_rd_addr;

  logic        acc_rd_we;
  logic [4:0]  acc_rd_waddr;
  logic [31:0] acc_rd_wdata;

  logic        cpu_rd_we;
  logic [4:0]  cpu_rd_waddr;
  logic [31:0] cpu_rd_wdata;

  modport slave (
    input  cpu_valid, cpu_instr, cpu_rs1_val, cpu_rs2_val, cpu_rd_addr,
    output cpu_ready,
    output acc_instr_valid, acc_instr, acc_rs1_val, acc_rs2_val, acc_rd_addr,
    input  acc_instr_ready,
    input  acc_rd_we, acc_rd_waddr, acc_rd_wdata,
    output cpu_rd_we, cpu_rd_waddr, cpu_rd_wdata
  );

  modport master (
    output cpu_valid, cpu_instr, cpu_rs1_val, cpu_rs2_val, cpu_rd_addr,
    input  cpu_ready,
    input  acc_instr_valid, acc_instr, acc_rs1_val, acc_rs2_val, acc_rd_addr,
    output acc_instr_ready,
    output acc_rd_we, acc_rd_waddr, acc_rd_wdata,
    input  cpu_rd_we, cpu_rd_waddr, cpu_rd_wdata
  );
endinterface

// File: rtl/rv32i_accel_cmd_queue_fifo.sv
// Show-ahead synchronous FIFO of accelerator commands; push-to-head 1 cycle.
// Push ignored when full, pop ignored when empty; caller gates with full/empty.
module accel_cmd_fifo
  import accel_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  accel_cmd_t       push_dat,
  input  logic             pop,
  output accel_cmd_t       head_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  accel_cmd_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // Storage needs no reset: head contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rv32i_accel_cmd_queue.sv
// Core-to-accelerator command queue with WAW scoreboard and registered writeback.
// Push-to-valid 1 cycle, writeback 1 cycle; cpu_ready drops when full or rd is busy.
module rv32i_accel_cmd_queue
  import accel_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  rv32i_accel_cmd_queue_if.slave  bus,
  output logic [31:0]             rd_busy_mask,
  output logic [CNT_W-1:0]        q_count,
  output logic [15:0]             ill_cnt
);

  accel_cmd_t  push_dat;
  accel_cmd_t  head_dat;
  logic        full;
  logic        empty;
  logic        offer_accel;
  logic        offer_prod;
  logic        xfer;
  logic        push;
  logic        pop;
  logic        ill;
  logic [31:0] mask_nxt;

  assign offer_accel = is_accel(bus.cpu_instr);
  assign offer_prod  = is_producer(bus.cpu_instr, bus.cpu_rd_addr);

  // Full is checked without looking at a same-cycle pop to keep timing short.
  assign bus.cpu_ready = !full && !(offer_prod && rd_busy_mask[bus.cpu_rd_addr]);
  assign xfer          = bus.cpu_valid && bus.cpu_ready;
  assign push          = xfer && offer_accel;
  assign ill           = xfer && !offer_accel;

  assign push_dat = '{instr:   bus.cpu_instr,
                      rs1_val: bus.cpu_rs1_val,
                      rs2_val: bus.cpu_rs2_val,
                      rd:      bus.cpu_rd_addr};

  assign bus.acc_instr_valid = !empty;
  assign pop                 = !empty && bus.acc_instr_ready;
  assign bus.acc_instr       = head_dat.instr;
  assign bus.acc_rs1_val     = head_dat.rs1_val;
  assign bus.acc_rs2_val     = head_dat.rs2_val;
  assign bus.acc_rd_addr     = head_dat.rd;

  accel_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty),
    .count    (q_count)
  );

  // Clear before set so a same-edge collision leaves the bit set.
  always_comb begin
    mask_nxt = rd_busy_mask;
    if (bus.acc_rd_we)      mask_nxt[bus.acc_rd_waddr] = 1'b0;
    if (push && offer_prod) mask_nxt[bus.cpu_rd_addr]  = 1'b1;
    mask_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_busy_mask     <= '0;
      bus.cpu_rd_we    <= 1'b0;
      bus.cpu_rd_waddr <= '0;
      bus.cpu_rd_wdata <= '0;
      ill_cnt          <= '0;
    end else begin
      rd_busy_mask     <= mask_nxt;
      bus.cpu_rd_we    <= bus.acc_rd_we;
      if (bus.acc_rd_we) begin
        bus.cpu_rd_waddr <= bus.acc_rd_waddr;
        bus.cpu_rd_wdata <= bus.acc_rd_wdata;
      end
      if (ill && (ill_cnt != 16'hFFFF)) ill_cnt <= ill_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rv32i_accel_cmd_queue.sv
// Directed bench for the accelerator command queue: reset, flow, backpressure,
// scoreboard, x0 handling, illegal filter and asynchronous reset.
module tb_rv32i_accel_cmd_queue;
  import accel_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic [31:0]      rd_busy_mask;
  logic [CNT_W-1:0] q_count;
  logic [15:0]      ill_cnt;
  int               n_chk;
  int               n_fail;

  rv32i_accel_cmd_queue_if bus ();

  rv32i_accel_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .rd_busy_mask (rd_busy_mask),
    .q_count      (q_count),
    .ill_cnt      (ill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] acc_word(input logic [2:0] f3);
    return {F7_ACCEL, 5'd2, 5'd1, f3, 5'd3, OPC_RTYPE};
  endfunction

  task automatic offer(input logic [31:0] instr, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [4:0] rd);
    bus.cpu_valid   = 1'b1;
    bus.cpu_instr   = instr;
    bus.cpu_rs1_val = rs1;
    bus.cpu_rs2_val = rs2;
    bus.cpu_rd_addr = rd;
    #1;
  endtask

  initial begin
    logic [31:0] add_w;
    n_chk  = 0;
    n_fail = 0;
    add_w  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, OPC_RTYPE};
    rst = 1'b1;
    bus.cpu_valid = 1'b0; bus.cpu_instr = '0; bus.cpu_rs1_val = '0;
    bus.cpu_rs2_val = '0; bus.cpu_rd_addr = '0; bus.acc_instr_ready = 1'b0;
    bus.acc_rd_we = 1'b0; bus.acc_rd_waddr = '0; bus.acc_rd_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_cpu_ready", bus.cpu_ready, 1);
    chk("rst_acc_valid", bus.acc_instr_valid, 0);
    chk("rst_rd_we", bus.cpu_rd_we, 0);
    chk("rst_rd_waddr", bus.cpu_rd_waddr, 0);
    chk("rst_rd_wdata", bus.cpu_rd_wdata, 0);
    chk("rst_mask", rd_busy_mask, 0);
    chk("rst_qcount", q_count, 0);
    chk("rst_ill", ill_cnt, 0);

    // Single command through an always-ready accelerator
    @(negedge clk);
    bus.acc_instr_ready = 1'b1;
    offer(acc_word(F3_AWR), 32'h0000_0102, 32'hDEAD_BEEF, 5'd3);
    chk("single_ready", bus.cpu_ready, 1);
    chk("single_no_bypass", bus.acc_instr_valid, 0);
    tick();
    bus.cpu_valid = 1'b0;
    chk("single_valid", bus.acc_instr_valid, 1);
    chk("single_instr", bus.acc_instr, acc_word(F3_AWR));
    chk("single_rs1", bus.acc_rs1_val, 32'h0000_0102);
    chk("single_rs2", bus.acc_rs2_val, 32'hDEAD_BEEF);
    chk("single_rd", bus.acc_rd_addr, 3);
    chk("single_cnt1", q_count, 1);
    tick();
    chk("single_cnt0", q_count, 0);
    chk("single_empty", bus.acc_instr_valid, 0);

    // Backpressure fill of 4 entries; the 5th offer stalls
    bus.acc_instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(acc_word(F3_AWR), 32'h10 + i, 32'h20 + i, 5'd4);
      chk($sformatf("fill_ready_%0d", i), bus.cpu_ready, (i < 4) ? 1 : 0);
      if (i < 4) tick();
    end
    bus.cpu_valid = 1'b0;
    chk("fill_cnt", q_count, 4);
    bus.acc_instr_ready = 1'b1;
    #1;
    chk("full_pop_ready", bus.cpu_ready, 0);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain_valid_%0d", j), bus.acc_instr_valid, 1);
      chk($sformatf("drain_rs1_%0d", j), bus.acc_rs1_val, 32'h10 + j);
      tick();
      if (j == 0) chk("ready_after_pop", bus.cpu_ready, 1);
    end
    chk("drain_cnt", q_count, 0);
    chk("drain_empty", bus.acc_instr_valid, 0);

    // Scoreboard set, WAW stall, writeback clear
    bus.acc_instr_ready = 1'b0;
    offer(acc_word(F3_STAT), 32'h1, 32'h2, 5'd5);
    chk("stat_ready", bus.cpu_ready, 1);
    tick();
    chk("stat_mask", rd_busy_mask, 32'h20);
    chk("waw_stall", bus.cpu_ready, 0);
    tick();
    chk("waw_cnt", q_count, 1);
    bus.acc_rd_we = 1'b1; bus.acc_rd_waddr = 5'd5; bus.acc_rd_wdata = 32'h2;
    #1;
    chk("wb_stall_hold", bus.cpu_ready, 0);
    tick();
    bus.acc_rd_we = 1'b0;
    #1;
    chk("wb_we", bus.cpu_rd_we, 1);
    chk("wb_waddr", bus.cpu_rd_waddr, 5);
    chk("wb_wdata", bus.cpu_rd_wdata, 32'h2);
    chk("wb_mask", rd_busy_mask, 0);
    chk("wb_unstall", bus.cpu_ready, 1);
    tick();
    bus.cpu_valid = 1'b0;
    chk("wb_pulse", bus.cpu_rd_we, 0);
    chk("stalled_accepted_mask", rd_busy_mask, 32'h20);
    chk("stalled_accepted_cnt", q_count, 2);
    bus.acc_rd_we = 1'b1; bus.acc_rd_waddr = 5'd5; bus.acc_rd_wdata = 32'h7;
    bus.acc_instr_ready = 1'b1;
    tick();
    bus.acc_rd_we = 1'b0;
    tick();
    chk("sb_clear_mask", rd_busy_mask, 0);
    chk("sb_clear_cnt", q_count, 0);

    // Writeback to a register that is not pending
    bus.acc_rd_we = 1'b1; bus.acc_rd_waddr = 5'd7; bus.acc_rd_wdata = 32'hCAFE_0001;
    tick();
    bus.acc_rd_we = 1'b0;
    chk("idle_wb_we", bus.cpu_rd_we, 1);
    chk("idle_wb_waddr", bus.cpu_rd_waddr, 7);
    chk("idle_wb_wdata", bus.cpu_rd_wdata, 32'hCAFE_0001);
    chk("idle_wb_mask", rd_busy_mask, 0);

    // BRD to x0 is queued but not tracked
    bus.acc_instr_ready = 1'b0;
    offer(acc_word(F3_BRD), 32'h3, 32'h4, 5'd0);
    tick();
    bus.cpu_valid = 1'b0;
    chk("x0_mask", rd_busy_mask, 0);
    chk("x0_cnt", q_count, 1);
    chk("x0_instr", bus.acc_instr, acc_word(F3_BRD));
    bus.acc_instr_ready = 1'b1;
    tick();
    chk("x0_drain", q_count, 0);

    // Non-accelerator words are consumed and counted
    bus.acc_instr_ready = 1'b0;
    offer(add_w, 32'h5, 32'h6, 5'd9);
    chk("ill_ready", bus.cpu_ready, 1);
    repeat (3) tick();
    bus.cpu_valid = 1'b0;
    chk("ill_cnt3", ill_cnt, 3);
    chk("ill_cnt_q", q_count, 0);
    chk("ill_valid", bus.acc_instr_valid, 0);

    // Asynchronous reset between edges
    offer(acc_word(F3_STAT), 32'h0, 32'h0, 5'd5);
    tick();
    offer(acc_word(F3_BRD), 32'h0, 32'h0, 5'd6);
    tick();
    offer(acc_word(F3_AWR), 32'h0, 32'h0, 5'd8);
    tick();
    bus.cpu_valid = 1'b0;
    chk("pre_arst_cnt", q_count, 3);
    chk("pre_arst_mask", rd_busy_mask, 32'h60);
    #1 rst = 1'b1;
    #1;
    chk("arst_cnt", q_count, 0);
    chk("arst_mask", rd_busy_mask, 0);
    chk("arst_valid", bus.acc_instr_valid, 0);
    chk("arst_ill", ill_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_accel_cmd_queue.md
# rv32i_accel_cmd_queue

Command queue and writeback return path between the RV32I core's custom-instruction port and the R-type transpose accelerator wrapper. It buffers up to `DEPTH` accelerator instructions so the core can keep issuing while the accelerator's `instr_ready` is low. It forwards them in order and registers the accelerator's `rd` writeback back to the core. A 32-bit register scoreboard tells the core pipeline which destination registers still have a result pending.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `PTR_W`, `$clog2(DEPTH)`: pointer width.
- `CNT_W`, `PTR_W+1`: occupancy width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_valid`  in  1  core offers an instruction.
- `cpu_ready`  out  1  queue accepts the offer this cycle.
- `cpu_instr`  in  32  raw instruction word.
- `cpu_rs1_val`, `cpu_rs2_val`  in  32  operand values.
- `cpu_rd_addr`  in  5  destination register.
- `acc_instr_valid`  out  1  head entry valid toward the accelerator.
- `acc_instr_ready`  in  1  accelerator accepts the head entry.
- `acc_instr`, `acc_rs1_val`, `acc_rs2_val`  out  32  head entry fields.
- `acc_rd_addr`  out  5  head entry destination.
- `acc_rd_we`  in  1  accelerator writeback strobe.
- `acc_rd_waddr`  in  5  writeback register.
- `acc_rd_wdata`  in  32  writeback data.
- `cpu_rd_we`  out  1  registered writeback strobe to the core.
- `cpu_rd_waddr`  out  5  registered writeback register.
- `cpu_rd_wdata`  out  32  registered writeback data.
- `rd_busy_mask`  out  32  bit n is 1 while a result for xn is pending; bit 0 is always 0.
- `q_count`  out  `CNT_W`  current occupancy.
- `ill_cnt`  out  16  count of rejected non-accelerator instructions; saturates at 0xFFFF.

## Operation
- Accelerator instruction: opcode `0110011` and funct7 `0000001`.
- Producer instruction: accelerator instruction with funct3 `010` (STAT) or `011` (BRD) and `cpu_rd_addr != 0`.
- Handshake: an offer transfers on `cpu_valid && cpu_ready`.
  - If the word is not an accelerator instruction, it is consumed, not queued, and `ill_cnt` increments.
  - Otherwise the entry {instr, rs1, rs2, rd} is pushed at the tail.
  - A producer also sets `rd_busy_mask[rd]`.
- `cpu_ready` = `!full && !(offer is a producer && rd_busy_mask[cpu_rd_addr])`.
  - This WAW stall guarantees at most one outstanding result per register.
  - Non-accelerator words are never stalled by the scoreboard but are stalled when the queue is full.
- Dequeue: the head is presented combinationally (show-ahead). It pops on `acc_instr_valid && acc_instr_ready`. Order is strictly FIFO.
- Writeback: `acc_rd_we` is registered into `cpu_rd_*` one cycle later. The same edge clears `rd_busy_mask[acc_rd_waddr]`.
- Same-edge set and clear of one bit cannot occur, because the WAW stall blocks it. If it does occur, set wins.
- A writeback to a register whose bit is already clear is forwarded unchanged; the mask is unaffected.
- Occupancy: `q_count` increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop. It never exceeds `DEPTH`.
- Pointers wrap modulo `DEPTH`.

## Timing
- Reset values:
  - `cpu_ready` = 1 (when `cpu_valid` = 0).
  - `acc_instr_valid` = 0.
  - `cpu_rd_we` = 0, `cpu_rd_waddr` = 0, `cpu_rd_wdata` = 0.
  - `rd_busy_mask` = 0, `q_count` = 0, `ill_cnt` = 0.
  - Head data fields are don't-care while `acc_instr_valid` = 0.
- Push-to-valid latency: 1 cycle. There is no bypass from `cpu_*` to `acc_*`.
- Writeback latency: 1 cycle. `cpu_rd_we` is a single-cycle pulse per `acc_rd_we` cycle.
- Full queue: `cpu_ready` = 0 even if a pop occurs that cycle (conservative). The slot is visible the following cycle.
- Empty queue: `acc_instr_valid` = 0 and `acc_instr_ready` is ignored.
- `rst` mid-operation: queue, scoreboard and counters clear immediately (asynchronously). Accelerator state is not the queue's responsibility; the system resets both together.

## Structure
- Shared package `accel_pkg`:
  - `OPC_RTYPE`, `F7_ACCEL`, `F3_AWR`, `F3_START`, `F3_STAT`, `F3_BRD`.
  - Struct `accel_cmd_t` {instr, rs1_val, rs2_val, rd}.
  - Function `is_producer(instr, rd)`.
- Sub-module `accel_cmd_fifo`:
  - Parameterised synchronous FIFO of `accel_cmd_t`, show-ahead.
  - Push/pop/full/empty/count outputs.
  - Instantiated once.
- The top holds decode, scoreboard, writeback register and `ill_cnt`.

## Test plan
- **Reset then single command.** Push AWR (funct3 000, rs1 = 0x0102, rs2 = 0xDEADBEEF) with `acc_instr_ready` = 1. Required: `acc_instr_valid` is high the next cycle with identical fields; `q_count` goes 1 → 0.
- **Backpressure fill.** Hold `acc_instr_ready` = 0 and push 5 commands with `DEPTH` = 4. Required: `cpu_ready` drops after the 4th push. Then release ready: the 4 commands drain in push order, and `cpu_ready` reasserts one cycle after the first pop.
- **Scoreboard.** Push STAT with rd = 5. Required: `rd_busy_mask` = 0x20 and a second STAT to rd = 5 stalls. Then drive `acc_rd_we`, waddr 5, wdata 0x2. Required next cycle: `cpu_rd_we` = 1, waddr 5, data 0x2, mask = 0, and the stalled STAT is accepted.
- **x0 destination.** Push BRD with rd = 0. Required: mask stays 0 and the command is queued normally.
- **Illegal filter.** Push an ADD (funct7 `0000000`) three times. Required: nothing queued and `ill_cnt` = 3.
- **Async reset mid-run.** With 3 queued and mask 0x60, assert `rst` between clock edges. Required: `q_count` = 0, mask = 0 and `acc_instr_valid` = 0 before the next edge.
